reg_read_port_9b: RTL and testbench

- Read-side companion to the 9-bit register bank: serves addressed read requests against NUM_REGS 9-bit registers and returns the data through a valid/ready output queue.
- Sits between the register bank and any consumer (datapath, debug reader) that needs back-pressured, in-order register reads.
- Flags out-of-range addresses with a sticky error.

---
 rtl/reg_read_port_9b.sv | 115 +++++++++++
 tb/tb_reg_read_port_9b.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_port_9b.sv
// Back-pressured, in-order read port for a bank of 9-bit registers.
// Requests are accepted into a one-deep address stage, sampled on the next edge, and queued for the consumer.
module reg_read_port_9b #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ready,
    input  logic [9*NUM_REGS-1:0] regs_flat,
    output logic                  rd_valid,
    output logic [8:0]            rd_data,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic                  err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [8:0]        mem_q [DEPTH];
    logic [8:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic              in_range;
    logic [8:0]        sample;
    logic [CNT_W:0]    credit;

    // Slots already claimed include the one in flight in stage 1, so a push always finds room.
    always_comb begin
        credit   = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
        rd_ready = (credit < (CNT_W + 1)'(DEPTH));
        rd_valid = (count_q != '0);
        rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
        err      = err_q;
    end

    always_comb begin
        sample   = '0;
        in_range = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (s1_addr_q == ADDR_W'(i)) begin
                sample   = regs_flat[9*i +: 9];
                in_range = 1'b1;
            end
        end
    end

    always_comb begin
        accept     = rd_req & rd_ready;
        push       = s1_valid_q;
        pop        = rd_valid & out_ready;

        s1_valid_d = accept;
        s1_addr_d  = accept ? rd_addr : s1_addr_q;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = sample;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (push && !in_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_read_port_9b.sv
// Self-checking bench for reg_read_port_9b: directed scenarios plus random traffic against a queue-based reference.
module tb_reg_read_port_9b;

    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DEPTH    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_ready;
    logic [9*NUM_REGS-1:0] regs_flat;
    logic                  rd_valid;
    logic [8:0]            rd_data;
    logic                  out_ready;
    logic                  err_clr;
    logic                  err;

    int checks   = 0;
    int failures = 0;

    // Reference: pending request (if any), queue of responses, sticky flag.
    bit [8:0]        exp_q[$];
    bit              m_s1;
    int              m_s1_addr;
    bit              m_err;

    reg_read_port_9b #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .regs_flat (regs_flat),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [8:0] ref_read(input int addr);
        if (addr < NUM_REGS) return regs_flat[9*addr +: 9];
        return 9'h000;
    endfunction

    function automatic bit model_ready();
        return (exp_q.size() + int'(m_s1)) < DEPTH;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_s1      = 1'b0;
        m_s1_addr = 0;
        m_err     = 1'b0;
    endtask

    task automatic model_update();
        bit ready;
        bit set;
        ready = model_ready();
        set   = 1'b0;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (m_s1) begin
            exp_q.push_back(ref_read(m_s1_addr));
            if (m_s1_addr >= NUM_REGS) set = 1'b1;
        end
        if (set) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_s1 = rd_req && ready;
        if (rd_req && ready) m_s1_addr = int'(rd_addr);
    endtask

    task automatic check_outputs();
        check_val("rd_ready", 32'(rd_ready), 32'(model_ready()));
        check_val("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
        check_val("rd_data", 32'(rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        check_val("err", 32'(err), 32'(m_err));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_update();
        else model_reset();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_reg(input int idx, input logic [8:0] val);
        regs_flat[9*idx +: 9] = val;
    endtask

    task automatic idle(input int n);
        rd_req    = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int accepted;
        int beats;
        logic [8:0] head0;

        rst       = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        regs_flat = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        model_reset();

        #3;
        check_val("reset_rd_valid", 32'(rd_valid), 32'h0);
        check_val("reset_rd_data", 32'(rd_data), 32'h0);
        check_val("reset_err", 32'(err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check_val("post_reset_ready", 32'(rd_ready), 32'h1);

        // Single read: valid for exactly one cycle, two edges after request.
        set_reg(3, 9'h1A5);
        rd_req  = 1'b1;
        rd_addr = 3'd3;
        step();
        rd_req = 1'b0;
        check_val("single_k_valid", 32'(rd_valid), 32'h0);
        step();
        check_val("single_k1_valid", 32'(rd_valid), 32'h1);
        check_val("single_k1_data", 32'(rd_data), 32'h1A5);
        step();
        check_val("single_k2_valid", 32'(rd_valid), 32'h0);
        check_val("single_err", 32'(err), 32'h0);

        // Back-to-back reads over every address.
        for (int i = 0; i < NUM_REGS; i++) set_reg(i, 9'(9'h100 + i));
        for (int i = 0; i < 8; i++) begin
            check_val("b2b_ready", 32'(rd_ready), 32'h1);
            rd_req  = 1'b1;
            rd_addr = 3'(i);
            step();
        end
        idle(3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Fill the queue under back-pressure, then drain it.
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 7; i++) begin
            if (rd_ready) accepted++;
            rd_req  = 1'b1;
            rd_addr = 3'(i % NUM_REGS);
            step();
            if (i == 2) head0 = rd_data;
        end
        rd_req = 1'b0;
        step();
        check_val("full_accepted", 32'(accepted), 32'd4);
        check_val("full_ready", 32'(rd_ready), 32'h0);
        check_val("full_head_stable", 32'(rd_data), 32'(head0));
        check_val("full_head_first", 32'(rd_data), 32'h100);
        out_ready = 1'b1;
        beats     = 0;
        for (int i = 0; i < 6; i++) begin
            if (rd_valid) beats++;
            step();
        end
        check_val("drain_beats", 32'(beats), 32'd4);
        check_val("drain_ready", 32'(rd_ready), 32'h1);

        // Out-of-range read and the clear/set priority of err.
        rd_req  = 1'b1;
        rd_addr = 3'd7;
        step();
        rd_req = 1'b0;
        step();
        check_val("oor_data", 32'(rd_data), 32'h0);
        check_val("oor_valid", 32'(rd_valid), 32'h1);
        check_val("oor_err", 32'(err), 32'h1);
        idle(3);
        check_val("oor_err_held", 32'(err), 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("err_clr_alone", 32'(err), 32'h0);
        rd_req  = 1'b1;
        rd_addr = 3'd6;
        step();
        rd_req  = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_val("err_set_wins", 32'(err), 32'h1);
        idle(2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Register updated right after the acceptance edge is what gets returned.
        set_reg(2, 9'h011);
        rd_req  = 1'b1;
        rd_addr = 3'd2;
        step();
        rd_req = 1'b0;
        set_reg(2, 9'h0FF);
        step();
        check_val("same_edge_write", 32'(rd_data), 32'h0FF);
        idle(2);

        // Reset with reads queued: outputs clear at once, nothing stale afterwards.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_req  = 1'b1;
            rd_addr = 3'(i);
            step();
        end
        rd_req = 1'b0;
        step();
        check_val("pre_reset_valid", 32'(rd_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_reset_valid", 32'(rd_valid), 32'h0);
        check_val("async_reset_data", 32'(rd_data), 32'h0);
        model_reset();
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        check_val("release_ready", 32'(rd_ready), 32'h1);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rd_valid) beats++;
        end
        check_val("no_stale_beats", 32'(beats), 32'd0);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            rd_req    = ($urandom_range(0, 3) != 0);
            rd_addr   = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int r = 0; r < NUM_REGS; r++) set_reg(r, 9'($urandom));
            end
            step();
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
